seq_packetizer: RTL and testbench
=================================

Name: seq_packetizer

Overview:
- Transmit-side counterpart of the sequence parser. Takes one parallel message (stream id, payload length, up to 37 payload bytes) and serialises it as a 32-bit word stream with a ready/valid/last handshake.
- Each packet carries an 8-byte header: a length word and a per-stream sequence word. Sequence numbers come from a 32-entry table, so the downstream parser sees contiguous sequences and no packetLost under normal operation.

Parameters:
- NUM_STREAMS, 32, sequence table depth; power of 2; table index = msgIn_stream[log2(NUM_STREAMS)-1:0].
- MAX_PAYLOAD, 37, maximum payload bytes per message; msgIn width = 8*MAX_PAYLOAD.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- msgIn  in  [0:8*MAX_PAYLOAD-1]  payload; byte k = msgIn[8k:8k+7], byte 0 sent first.
- msgIn_len  in  6  payload byte count; valid range 1..MAX_PAYLOAD.
- msgIn_stream  in  16  stream id.
- msgIn_val  in  1  message valid.
- msgIn_ready  out  1  message accepted when val&ready.
- dataOut  out  32  output word.
- dataOut_val  out  1  word valid.
- dataOut_ready  in  1  downstream accepts word.
- dataOut_last  out  1  final word of packet.
- badLen  out  1  one-cycle pulse: a message with an illegal length was dropped.

Behaviour:
- Reset (async, active-high):
  - state=IDLE; all table entries = 1.
  - dataOut=0, dataOut_val=0, dataOut_last=0, badLen=0, msgIn_ready=1.
  - A packet in flight is abandoned without emitting a last word.
- Message acceptance:
  - msgIn_ready = (state==IDLE). Accept on msgIn_val & msgIn_ready.
  - On accept, capture payload, len, stream and seq = table[idx]. In the same edge, write table[idx] <= seq+1 (32-bit wrap, 0xFFFFFFFF -> 0).
- Illegal length (msgIn_len==0 or > MAX_PAYLOAD):
  - Message is consumed but nothing is emitted; table is unchanged.
  - badLen pulses high in the cycle after accept; state stays IDLE.
- States:
  - IDLE -> HDR on legal accept.
  - HDR -> SEQ on dataOut_ready.
  - SEQ -> DATA on dataOut_ready.
  - In DATA, each dataOut_ready advances the word index; on the last word with ready, DATA -> IDLE.
- Word formats (byte-swapped fields, matching the parser):
  - Total length T = len+8, 16 bits.
  - HDR word = {T[7:0], T[15:8], stream[7:0], stream[15:8]}.
  - SEQ word = {seq[7:0], seq[15:8], seq[23:16], seq[31:24]}.
  - DATA word i = payload bytes 4i..4i+3, placed at [31:24],[23:16],[15:8],[7:0].
  - Bytes beyond len in the final word are 0.
- Word count = 2 + ceil(len/4). dataOut_last is high only on the final DATA word.
- Handshake and latency:
  - dataOut_val is high in HDR, SEQ and DATA.
  - dataOut and dataOut_last hold stable while val & !ready.
  - dataOut = 0 when dataOut_val = 0.
  - Latency: accept at edge N; HDR valid in cycle N+1.
  - After the last word is accepted there is one IDLE cycle, so the minimum inter-packet bubble is 1 cycle.
- Streams sharing low index bits (e.g. 0x0003 and 0x0023) share one table entry. The full 16-bit id is still emitted in the header.
- No simultaneous accept and emit: the IDLE/busy states are mutually exclusive.

Optional Feature:
- Macro SEQ_GAP_INJECT_EN.
- Defined:
  - Adds input port seqSkip (1 bit), sampled at message accept.
  - If seqSkip=1, the emitted seq = table[idx]+1 and table[idx] <= table[idx]+2, so the receiver must flag packetLost.
  - seqSkip is ignored for illegal-length messages.
- Undefined: the port is absent and sequences per entry are strictly contiguous.

Test Plan:
- Stream 0x0003, len 5, bytes 01..05 after reset -> 32'h0D000300, 32'h01000000, 32'h01020304, 32'h05000000 (last=1 on the 4th word).
- Second message on stream 0x0003, then one on stream 0x0023 -> SEQ words 32'h02000000 then 32'h03000000; header of the third = {T,T,23,00}.
- len 37 with dataOut_ready held low 3 cycles on word 2 -> word held stable; 12 words total; final word = {byte36, 24'h0}; msgIn_ready=0 throughout.
- len 0 and len 40 -> badLen pulses once each; no dataOut_val; the next legal packet carries seq 1.
- Assert reset mid-DATA -> outputs zero immediately; next packet on the same stream carries seq 1.
- (SEQ_GAP_INJECT_EN) seqSkip=1 on the first packet of stream 5 -> SEQ word 32'h02000000; the next normal packet -> 32'h03000000.

Source files
------------

// File: rtl/seq_packetizer.sv
// Serialises one parallel message into a header/sequence/payload word stream.
// Optional SEQ_GAP_INJECT_EN adds a seqSkip input that deliberately skips one sequence number.
module seq_packetizer #(
  parameter int NUM_STREAMS = 32,
  parameter int MAX_PAYLOAD = 37
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [0:8*MAX_PAYLOAD-1]   msgIn,
  input  logic [5:0]                 msgIn_len,
  input  logic [15:0]                msgIn_stream,
  input  logic                       msgIn_val,
`ifdef SEQ_GAP_INJECT_EN
  input  logic                       seqSkip,
`endif
  output logic                       msgIn_ready,
  output logic [31:0]                dataOut,
  output logic                       dataOut_val,
  input  logic                       dataOut_ready,
  output logic                       dataOut_last,
  output logic                       badLen
);

  localparam int IDXW = $clog2(NUM_STREAMS);
  localparam int NW   = (MAX_PAYLOAD + 3) / 4;
  localparam int BUFW = 32 * NW;
  localparam int IW   = $clog2(NW + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_SEQ,
    S_DATA
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [31:0]       r_tab [NUM_STREAMS];
  logic [0:BUFW-1]   r_buf;
  logic [0:BUFW-1]   w_mask;
  logic [5:0]        r_len;
  logic [15:0]       r_stream;
  logic [31:0]       r_seq;
  logic [31:0]       w_seq;
  logic [IW-1:0]     r_idx;
  logic [IW-1:0]     r_last;
  logic [IW-1:0]     w_nlast;
  logic [6:0]        w_nw;
  logic              r_bad;
  logic              w_acc;
  logic              w_legal;
  logic              w_skip;
  logic [IDXW-1:0]   w_tidx;
  logic [15:0]       w_tot;
  logic              w_is_last;

`ifdef SEQ_GAP_INJECT_EN
  assign w_skip = seqSkip;
`else
  assign w_skip = 1'b0;
`endif

  assign w_acc     = msgIn_val && (r_state == S_IDLE);
  assign w_legal   = (msgIn_len != 6'd0) &&
                     (int'(msgIn_len) <= MAX_PAYLOAD);
  assign w_tidx    = msgIn_stream[IDXW-1:0];
  assign w_seq     = r_tab[w_tidx] + {31'd0, w_skip};
  assign w_nw      = ({1'b0, msgIn_len} + 7'd3) >> 2;
  assign w_nlast   = IW'(w_nw - 7'd1);
  assign w_tot     = {10'd0, r_len} + 16'd8;
  assign w_is_last = (r_idx == r_last);
  assign badLen    = r_bad;

  // Zero bytes past len at capture so the tail word needs no masking later
  always_comb begin
    w_mask = '0;
    for (int k = 0; k < MAX_PAYLOAD; k++) begin
      if (k < int'(msgIn_len))
        w_mask[8*k +: 8] = msgIn[8*k +: 8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_STREAMS; i++)
        r_tab[i] <= 32'd1;
      r_buf    <= '0;
      r_len    <= '0;
      r_stream <= '0;
      r_seq    <= '0;
      r_idx    <= '0;
      r_last   <= '0;
      r_bad    <= 1'b0;
    end else begin
      r_bad <= w_acc && !w_legal;
      if (w_acc && w_legal) begin
        r_buf         <= w_mask;
        r_len         <= msgIn_len;
        r_stream      <= msgIn_stream;
        r_seq         <= w_seq;
        r_tab[w_tidx] <= w_seq + 32'd1;
        r_idx         <= '0;
        r_last        <= w_nlast;
      end else if (r_state == S_DATA && dataOut_ready && !w_is_last) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  always_comb begin
    w_next       = r_state;
    msgIn_ready  = 1'b0;
    dataOut      = '0;
    dataOut_val  = 1'b0;
    dataOut_last = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        msgIn_ready = 1'b1;
        if (w_acc && w_legal)
          w_next = S_HDR;
      end
      S_HDR: begin
        dataOut_val = 1'b1;
        dataOut = {w_tot[7:0], w_tot[15:8],
                   r_stream[7:0], r_stream[15:8]};
        if (dataOut_ready)
          w_next = S_SEQ;
      end
      S_SEQ: begin
        dataOut_val = 1'b1;
        dataOut = {r_seq[7:0], r_seq[15:8],
                   r_seq[23:16], r_seq[31:24]};
        if (dataOut_ready)
          w_next = S_DATA;
      end
      S_DATA: begin
        dataOut_val  = 1'b1;
        dataOut      = r_buf[32*int'(r_idx) +: 32];
        dataOut_last = w_is_last;
        if (dataOut_ready && w_is_last)
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_packetizer.sv
// Scoreboard bench for seq_packetizer: stimulus queues expected words,
// a negedge monitor pops and compares each accepted output word.
module tb_seq_packetizer;

  localparam int MAXP = 37;

  logic              clk = 1'b0;
  logic              reset;
  logic [0:8*MAXP-1] msgIn;
  logic [5:0]        msgIn_len;
  logic [15:0]       msgIn_stream;
  logic              msgIn_val;
  logic              seqSkip;
  logic              msgIn_ready;
  logic [31:0]       dataOut;
  logic              dataOut_val;
  logic              dataOut_ready;
  logic              dataOut_last;
  logic              badLen;

  seq_packetizer dut (
    .clk           (clk),
    .reset         (reset),
    .msgIn         (msgIn),
    .msgIn_len     (msgIn_len),
    .msgIn_stream  (msgIn_stream),
    .msgIn_val     (msgIn_val),
`ifdef SEQ_GAP_INJECT_EN
    .seqSkip       (seqSkip),
`endif
    .msgIn_ready   (msgIn_ready),
    .dataOut       (dataOut),
    .dataOut_val   (dataOut_val),
    .dataOut_ready (dataOut_ready),
    .dataOut_last  (dataOut_last),
    .badLen        (badLen)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } exp_t;

  exp_t        q[$];
  logic [31:0] tab [32];
  int          checks  = 0;
  int          errors  = 0;
  int          nxfer   = 0;
  int          nbad    = 0;
  int          exp_bad = 0;
  logic        held_v  = 1'b0;
  logic [31:0] held_d;
  logic        held_l;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic l);
    exp_t e;
    e.d = d;
    e.l = l;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      held_v = 1'b0;
    end else begin
      if (badLen) nbad++;
      if (held_v) begin
        chk("hold_data", dataOut, held_d);
        chk("hold_last", {31'd0, dataOut_last}, {31'd0, held_l});
      end
      held_v = dataOut_val && !dataOut_ready;
      held_d = dataOut;
      held_l = dataOut_last;
      if (dataOut_val) begin
        chk("busy_ready", {31'd0, msgIn_ready}, 32'd0);
        if (dataOut_ready) begin
          nxfer++;
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %h expected none", dataOut);
          end else begin
            e = q.pop_front();
            chk("word", dataOut, e.d);
            chk("last", {31'd0, dataOut_last}, {31'd0, e.l});
          end
        end
      end else begin
        chk("idle_zero", dataOut, 32'd0);
      end
    end
  end

  task automatic model(input logic [15:0] st, input int len,
                       input int base, input bit skip);
    logic [31:0] s;
    logic [15:0] t;
    logic [31:0] w;
    int nw;
    int b;
    if (len == 0 || len > MAXP) begin
      exp_bad++;
    end else begin
      t = 16'(len + 8);
      s = tab[st[4:0]] + {31'd0, skip};
      tab[st[4:0]] = s + 32'd1;
      push({t[7:0], t[15:8], st[7:0], st[15:8]}, 1'b0);
      push({s[7:0], s[15:8], s[23:16], s[31:24]}, 1'b0);
      nw = (len + 3) / 4;
      for (int i = 0; i < nw; i++) begin
        w = 32'd0;
        for (int j = 0; j < 4; j++) begin
          b = 4*i + j;
          if (b < len) w[31-8*j -: 8] = 8'(base + b);
        end
        push(w, i == nw - 1);
      end
    end
  endtask

  task automatic drive(input logic [15:0] st, input int len,
                       input int base, input bit skip);
    int n = 0;
    while (!msgIn_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!msgIn_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got ready=0 expected 1");
    end
    for (int k = 0; k < MAXP; k++)
      msgIn[8*k +: 8] = (k < len) ? 8'(base + k) : 8'hEE;
    msgIn_len    = 6'(len);
    msgIn_stream = st;
    seqSkip      = skip;
    msgIn_val    = 1'b1;
    @(posedge clk); #1;
    msgIn_val = 1'b0;
    seqSkip   = 1'b0;
  endtask

  task automatic send(input logic [15:0] st, input int len,
                      input int base, input bit skip);
    model(st, len, base, skip);
    drive(st, len, base, skip);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("drain_left", q.size(), 32'd0);
  endtask

  task automatic wait_data(input int target);
    int n = 0;
    while (nxfer < target && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_data", nxfer, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    reset         = 1'b1;
    msgIn         = '0;
    msgIn_len     = '0;
    msgIn_stream  = '0;
    msgIn_val     = 1'b0;
    seqSkip       = 1'b0;
    dataOut_ready = 1'b1;
    for (int i = 0; i < 32; i++) tab[i] = 32'd1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, msgIn_ready}, 32'd1);
    chk("rst_val", {31'd0, dataOut_val}, 32'd0);
    chk("rst_data", dataOut, 32'd0);
    chk("rst_last", {31'd0, dataOut_last}, 32'd0);
    chk("rst_bad", {31'd0, badLen}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // hand-computed first packet
    push(32'h0D000300, 1'b0);
    push(32'h01000000, 1'b0);
    push(32'h01020304, 1'b0);
    push(32'h05000000, 1'b1);
    tab[3] = 32'd2;
    drive(16'h0003, 5, 8'h01, 1'b0);
    drain();

    // shared table entry 0x0003 / 0x0023
    push(32'h0C000300, 1'b0);
    push(32'h02000000, 1'b0);
    push(32'h10111213, 1'b1);
    push(32'h0B002300, 1'b0);
    push(32'h03000000, 1'b0);
    push(32'h20212200, 1'b1);
    tab[3] = 32'd4;
    drive(16'h0003, 4, 8'h10, 1'b0);
    drive(16'h0023, 3, 8'h20, 1'b0);
    drain();

    // maximum length with a stall on the first data word
    n0 = nxfer;
    send(16'h0009, 37, 8'h40, 1'b0);
    wait_data(n0 + 2);
    dataOut_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    dataOut_ready = 1'b1;
    drain();
    chk("len37_words", nxfer - n0, 32'd12);

    // illegal lengths are dropped, table untouched
    n0 = nxfer;
    send(16'h000C, 0, 8'h50, 1'b0);
    send(16'h000C, 40, 8'h60, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("bad_no_words", nxfer - n0, 32'd0);
    chk("bad_count", nbad, exp_bad);
    send(16'h000C, 2, 8'h70, 1'b0);
    drain();

    // reset in the middle of a data phase
    n0 = nxfer;
    send(16'h0014, 12, 8'h80, 1'b0);
    wait_data(n0 + 2);
    dataOut_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_val", {31'd0, dataOut_val}, 32'd0);
    chk("mid_rst_data", dataOut, 32'd0);
    chk("mid_rst_last", {31'd0, dataOut_last}, 32'd0);
    chk("mid_rst_ready", {31'd0, msgIn_ready}, 32'd1);
    q.delete();
    for (int i = 0; i < 32; i++) tab[i] = 32'd1;
    @(posedge clk); #1;
    reset = 1'b0;
    dataOut_ready = 1'b1;
    send(16'h0014, 1, 8'h90, 1'b0);
    send(16'h0003, 2, 8'hA0, 1'b0);
    drain();

`ifdef SEQ_GAP_INJECT_EN
    push(32'h0C000500, 1'b0);
    push(32'h02000000, 1'b0);
    push(32'hB0B1B2B3, 1'b1);
    push(32'h0C000500, 1'b0);
    push(32'h03000000, 1'b0);
    push(32'hC0C1C2C3, 1'b1);
    tab[5] = 32'd4;
    drive(16'h0005, 4, 8'hB0, 1'b1);
    drive(16'h0005, 4, 8'hC0, 1'b0);
    drain();
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("bad_total", nbad, exp_bad);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
